snes_pad_responder: RTL



---
 rtl/snes_pad_responder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/snes_pad_responder.sv
// Device side of the SNES pad serial link: answers host latch/clock with a 16-bit
// active-low word {ID_BITS, ~buttons}, oversampling the asynchronous pad lines on cpu_clock.
module snes_pad_responder #(
    parameter int          SYNC_STAGES    = 2,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096,
    parameter logic [3:0]  ID_BITS        = 4'b1111
) (
    input  logic        cpu_clock,
    input  logic        rst,
    input  logic        pad_latch,
    input  logic        pad_clock,
    output logic        pad_data,
    input  logic [11:0] buttons,
    output logic        frame_done,
    output logic        busy,
    output logic [4:0]  bit_index,
    output logic [7:0]  frame_count
);
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t            state, state_nxt;
    logic [SYNC_N-1:0] latch_sync, clock_sync;
    logic              latch_hist, clock_hist;
    logic [15:0]       shift_reg, shift_nxt;
    logic [15:0]       tcount, tcount_nxt, tcount_inc;
    logic [4:0]        bit_nxt;
    logic [7:0]        fcount_nxt;
    logic              done_nxt;
    logic              timed_out;
    logic              latch_s, clock_s;
    logic              latch_rise, latch_fall, clock_rise, clock_fall;
    logic [15:0]       load_word;

    // Synchronisers reset to the idle line levels so reset itself creates no edges.
    always_ff @(posedge cpu_clock) begin
        if (rst) begin
            latch_sync <= '0;
            clock_sync <= '1;
            latch_hist <= 1'b0;
            clock_hist <= 1'b1;
        end else begin
            latch_sync <= {latch_sync[SYNC_N-2:0], pad_latch};
            clock_sync <= {clock_sync[SYNC_N-2:0], pad_clock};
            latch_hist <= latch_sync[SYNC_N-1];
            clock_hist <= clock_sync[SYNC_N-1];
        end
    end

    assign latch_s    = latch_sync[SYNC_N-1];
    assign clock_s    = clock_sync[SYNC_N-1];
    assign latch_rise = latch_s & ~latch_hist;
    assign latch_fall = ~latch_s & latch_hist;
    assign clock_rise = clock_s & ~clock_hist;
    assign clock_fall = ~clock_s & clock_hist;
    assign load_word  = {ID_BITS, ~buttons};
    assign tcount_inc = tcount + 16'd1;
    assign timed_out  = (tcount_inc == TIMEOUT_CYCLES);

    always_ff @(posedge cpu_clock) begin
        if (rst) begin
            state       <= IDLE;
            shift_reg   <= 16'hFFFF;
            tcount      <= '0;
            bit_index   <= '0;
            frame_count <= '0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_nxt;
            shift_reg   <= shift_nxt;
            tcount      <= tcount_nxt;
            bit_index   <= bit_nxt;
            frame_count <= fcount_nxt;
            frame_done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shift_nxt  = shift_reg;
        tcount_nxt = tcount;
        bit_nxt    = bit_index;
        fcount_nxt = frame_count;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                shift_nxt  = 16'hFFFF;
                bit_nxt    = '0;
                tcount_nxt = '0;
                if (latch_s) begin
                    state_nxt = LOAD;
                    shift_nxt = load_word;
                end
            end
            LOAD: begin
                // Clock edges under a high latch only keep the frame alive.
                shift_nxt = load_word;
                bit_nxt   = '0;
                if (latch_fall) begin
                    state_nxt  = SHIFT;
                    tcount_nxt = '0;
                end else if (latch_rise || clock_rise || clock_fall) begin
                    tcount_nxt = '0;
                end else if (timed_out) begin
                    state_nxt  = IDLE;
                    shift_nxt  = 16'hFFFF;
                    tcount_nxt = '0;
                end else begin
                    tcount_nxt = tcount_inc;
                end
            end
            SHIFT: begin
                if (latch_rise) begin
                    state_nxt  = LOAD;
                    shift_nxt  = load_word;
                    bit_nxt    = '0;
                    tcount_nxt = '0;
                end else if (clock_rise) begin
                    shift_nxt  = {1'b0, shift_reg[15:1]};
                    bit_nxt    = bit_index + 5'd1;
                    tcount_nxt = '0;
                    if (bit_index == 5'd15) begin
                        state_nxt  = DONE;
                        done_nxt   = 1'b1;
                        fcount_nxt = frame_count + 8'd1;
                    end
                end else if (latch_fall || clock_fall) begin
                    tcount_nxt = '0;
                end else if (timed_out) begin
                    state_nxt  = IDLE;
                    shift_nxt  = 16'hFFFF;
                    bit_nxt    = '0;
                    tcount_nxt = '0;
                end else begin
                    tcount_nxt = tcount_inc;
                end
            end
            DONE: begin
                if (latch_rise) begin
                    state_nxt  = LOAD;
                    shift_nxt  = load_word;
                    bit_nxt    = '0;
                    tcount_nxt = '0;
                end else if (latch_s) begin
                    tcount_nxt = '0;
                end else if (timed_out) begin
                    state_nxt  = IDLE;
                    shift_nxt  = 16'hFFFF;
                    bit_nxt    = '0;
                    tcount_nxt = '0;
                end else begin
                    tcount_nxt = tcount_inc;
                end
            end
            default: begin
                state_nxt  = IDLE;
                shift_nxt  = 16'hFFFF;
                bit_nxt    = '0;
                tcount_nxt = '0;
            end
        endcase
    end

    // A real pad drives low once the word is exhausted.
    always_comb begin
        pad_data = shift_reg[0];
        if (state == DONE)
            pad_data = 1'b0;
        else if (state == IDLE)
            pad_data = 1'b1;
    end

    assign busy = (state == LOAD) || (state == SHIFT);

endmodule
